segment_encoder: RTL

- Inverse of the alphanumeric display decoder: receives a 15-bit segment pattern serially, one bit per clock, and recovers the 4-bit hex code that produces that pattern.
- Output is a registered code with a valid/ready handshake and an error flag for patterns outside the 16-entry glyph table.
- Sits between display-readback/self-test logic and any consumer checking what the display is actually showing.

---
 rtl/segment_encoder.sv | 79 +++++++
 1 files changed

// File: rtl/segment_encoder.sv
// segment_encoder: serial 15-bit segment pattern to 4-bit hex code with valid/ready output.
// Optional SEG_ENCODER_ERRCNT_EN adds a saturating unmatched-frame counter on err_count.
module segment_encoder #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ser_valid,
  input  logic       ser_start,
  input  logic       ser_data,
  output logic       ser_ready,
  output logic [3:0] code_out,
  output logic       code_error,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [7:0] err_count
);
  typedef enum logic [1:0] {IDLE, SHIFT, LOOKUP, OUT} state_t;
  localparam logic [14:0] glyph [16] = '{
    15'h0C3F, 15'h0406, 15'h00DB, 15'h00CF, 15'h00E6, 15'h00ED, 15'h00FD, 15'h1401,
    15'h00FF, 15'h00E7, 15'h00F7, 15'h128F, 15'h0039, 15'h120F, 15'h00F9, 15'h00F1
  };
  state_t state, state_nxt;
  logic [14:0] sr;
  logic [3:0] cnt;
  logic hit;
  logic [3:0] hit_code;
  logic take;
  assign ser_ready  = state == IDLE || state == SHIFT;
  assign code_valid = state == OUT;
  assign take = ser_valid && (ser_start ? ser_ready : state == SHIFT);
  always_comb begin
    hit = 1'b0;
    hit_code = 4'd0;
    for (int i = 0; i < 16; i++)
      if (sr == glyph[i]) begin
        hit = 1'b1;
        hit_code = 4'(i);
      end
  end
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE   ? (ser_valid && ser_start ? SHIFT : IDLE) :
                state == SHIFT  ? (ser_valid && !ser_start && cnt == 4'd14 ? LOOKUP : SHIFT) :
                state == LOOKUP ? OUT :
                                  (code_ready ? IDLE : OUT);
  end
  always_ff @(posedge Clk)
    if (Reset) state <= IDLE;
    else state <= state_nxt;
  // A start bit always reloads the register so a mid-frame restart drops earlier bits.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sr <= '0;
      cnt <= '0;
      code_out <= '0;
      code_error <= 1'b0;
    end else begin
      if (take) begin
        sr <= ser_start ? (MSB_FIRST ? {14'd0, ser_data} : {ser_data, 14'd0}) :
                          (MSB_FIRST ? {sr[13:0], ser_data} : {ser_data, sr[14:1]});
        cnt <= ser_start ? 4'd1 : cnt + 4'd1;
      end
      if (state == LOOKUP) begin
        code_out <= hit_code;
        code_error <= !hit;
      end
    end
  end
`ifdef SEG_ENCODER_ERRCNT_EN
  logic [7:0] err_q;
  always_ff @(posedge Clk)
    if (Reset) err_q <= '0;
    else if (state == LOOKUP && !hit && err_q != 8'hFF) err_q <= err_q + 8'd1;
  assign err_count = err_q;
`else
  assign err_count = 8'd0;
`endif
endmodule
